// File: rtl/datapath_mem_core.sv
// Multicycle-CPU datapath slice: IR, 16-entry register file, immediate generator,
// registered signed ALU, word memory with memory-mapped I/O, and an MDR.
module datapath_mem_core #(
    parameter int         DATA_W      = 16,
    parameter int         MEM_DEPTH   = 256,
    parameter logic [7:0] IO_IN_ADDR  = 8'hFF,
    parameter logic [7:0] IO_OUT_ADDR = 8'hFE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               aluOp_i,
    input  logic                     aluSrcA_i,
    input  logic                     aluSrcB_i,
    input  logic                     writeEnable_i,
    input  logic [DATA_W-1:0]        dataWrite_i,
    input  logic [1:0]               immShift_i,
    input  logic [1:0]               numBits_i,
    input  logic                     irWrite_i,
    input  logic [15:0]              instruction_i,
    input  logic [DATA_W-1:0]        pc_i,
    input  logic [DATA_W-1:0]        memData_i,
    input  logic [15:0]              memAddr_i,
    input  logic                     memWe_i,
    input  logic [DATA_W-1:0]        inputWire_i,
    output logic signed [DATA_W-1:0] a_o,
    output logic signed [DATA_W-1:0] b_o,
    output logic signed [DATA_W-1:0] aluOut_o,
    output logic [3:0]               op_o,
    output logic [DATA_W-1:0]        immediateGenerated_o,
    output logic [DATA_W-1:0]        memQ_o,
    output logic [DATA_W-1:0]        mdrOut_o,
    output logic [DATA_W-1:0]        outputWire_o
);

    logic [15:0]              ir_q;
    logic [DATA_W-1:0]        regFile_q [16];
    logic signed [DATA_W-1:0] a_q, b_q, aluOut_q;
    logic [DATA_W-1:0]        memQ_q, mdr_q, outputWire_q;
    logic [DATA_W-1:0]        mem [MEM_DEPTH];

    logic [3:0]               rd, rs;
    logic [7:0]               wordAddr;
    logic [DATA_W-1:0]        immField;
    logic signed [DATA_W-1:0] opA, opB, aluOut_d;
    logic                     unusedAddrBits;

    assign rd       = ir_q[11:8];
    assign rs       = ir_q[7:4];
    assign wordAddr = memAddr_i[8:1];
    assign unusedAddrBits = ^{memAddr_i[15:9], memAddr_i[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= '0;
        end else if (irWrite_i) begin
            ir_q <= instruction_i;
        end
    end

    // Reads use the register contents from before this edge, so a write to rd
    // shows up in A only on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regFile_q[i] <= '0;
            end
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= (rd == 4'd0) ? '0 : regFile_q[rd];
            b_q <= (rs == 4'd0) ? '0 : regFile_q[rs];
            if (writeEnable_i && (rd != 4'd0)) begin
                regFile_q[rd] <= dataWrite_i;
            end
        end
    end

    always_comb begin
        immField = '0;
        case (numBits_i)
            2'd0:    immField = {{(DATA_W-4){ir_q[3]}}, ir_q[3:0]};
            2'd1:    immField = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
            2'd2:    immField = {{(DATA_W-12){ir_q[11]}}, ir_q[11:0]};
            default: immField = {{(DATA_W-8){1'b0}}, ir_q[7:0]};
        endcase
        immediateGenerated_o = immField << immShift_i;
    end

    always_comb begin
        opA      = aluSrcA_i ? $signed(pc_i) : a_q;
        opB      = aluSrcB_i ? $signed(immediateGenerated_o) : b_q;
        aluOut_d = '0;
        case (aluOp_i)
            3'd0:    aluOut_d = opA + opB;
            3'd1:    aluOut_d = opA - opB;
            3'd2:    aluOut_d = opA & opB;
            3'd3:    aluOut_d = opA | opB;
            3'd4:    aluOut_d = opA ^ opB;
            3'd5:    aluOut_d = opA << opB[3:0];
            3'd6:    aluOut_d = opA >>> opB[3:0];
            default: aluOut_d = {{(DATA_W-1){1'b0}}, (opA < opB)};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluOut_q <= '0;
        end else begin
            aluOut_q <= aluOut_d;
        end
    end

    // The array has no reset; gating on rst_n keeps a write from landing while
    // reset is held, including one that was pending when reset arrived.
    always_ff @(posedge clk) begin
        if (rst_n && memWe_i) begin
            mem[wordAddr] <= memData_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memQ_q       <= '0;
            mdr_q        <= '0;
            outputWire_q <= '0;
        end else begin
            memQ_q <= (wordAddr == IO_IN_ADDR) ? inputWire_i : mem[wordAddr];
            mdr_q  <= memQ_q;
            if (memWe_i && (wordAddr == IO_OUT_ADDR)) begin
                outputWire_q <= memData_i;
            end
        end
    end

    assign a_o          = a_q;
    assign b_o          = b_q;
    assign aluOut_o     = aluOut_q;
    assign op_o         = ir_q[15:12];
    assign memQ_o       = memQ_q;
    assign mdrOut_o     = mdr_q;
    assign outputWire_o = outputWire_q;

endmodule

// File: tb/tb_datapath_mem_core.sv
// Self-checking bench for datapath_mem_core: directed scenarios followed by random
// cycles, all compared against an arithmetic reference model of the datapath.
module tb_datapath_mem_core;

    logic        clk = 1'b0;
    logic        rstN;
    logic [2:0]  aluOp;
    logic        aluSrcA, aluSrcB, writeEnable, irWrite, memWe;
    logic [15:0] dataWrite, instruction, pc, memData, memAddr, inputWire;
    logic [1:0]  immShift, numBits;
    logic [15:0] a, b, aluOut, imm, memQ, mdrOut, outputWire;
    logic [3:0]  op;

    int testCount = 0;
    int failCount = 0;

    // Reference model state
    logic [15:0] mIr, mA, mB, mAlu, mMemQ, mMdr, mOut;
    logic [15:0] mRegs [16];
    logic [15:0] mMem  [256];
    bit          mValid [256];
    bit          mQKnown, mMdrKnown;

    datapath_mem_core dut (
        .clk                  (clk),
        .rst_n                (rstN),
        .aluOp_i              (aluOp),
        .aluSrcA_i            (aluSrcA),
        .aluSrcB_i            (aluSrcB),
        .writeEnable_i        (writeEnable),
        .dataWrite_i          (dataWrite),
        .immShift_i           (immShift),
        .numBits_i            (numBits),
        .irWrite_i            (irWrite),
        .instruction_i        (instruction),
        .pc_i                 (pc),
        .memData_i            (memData),
        .memAddr_i            (memAddr),
        .memWe_i              (memWe),
        .inputWire_i          (inputWire),
        .a_o                  (a),
        .b_o                  (b),
        .aluOut_o             (aluOut),
        .op_o                 (op),
        .immediateGenerated_o (imm),
        .memQ_o               (memQ),
        .mdrOut_o             (mdrOut),
        .outputWire_o         (outputWire)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] immOf(input logic [15:0] ir, input logic [1:0] nb,
                                          input logic [1:0] sh);
        int v;
        case (nb)
            2'd0: begin v = int'(ir[3:0]);  if (v >= 8)    v -= 16;   end
            2'd1: begin v = int'(ir[7:0]);  if (v >= 128)  v -= 256;  end
            2'd2: begin v = int'(ir[11:0]); if (v >= 2048) v -= 4096; end
            default: v = int'(ir[7:0]);
        endcase
        return 16'(v * (1 << sh));
    endfunction

    function automatic logic [15:0] aluOf(input logic [2:0] f, input logic [15:0] x,
                                          input logic [15:0] y);
        int sx, sy, r, n;
        sx = $signed(x);
        sy = $signed(y);
        n  = int'(y) % 16;
        case (f)
            3'd0:    r = sx + sy;
            3'd1:    r = sx - sy;
            3'd2:    r = int'(x & y);
            3'd3:    r = int'(x | y);
            3'd4:    r = int'(x ^ y);
            3'd5:    r = sx * (1 << n);
            3'd6:    r = sx >>> n;
            default: r = (sx < sy) ? 1 : 0;
        endcase
        return 16'(r);
    endfunction

    task automatic modelReset();
        mIr = '0; mA = '0; mB = '0; mAlu = '0; mMemQ = '0; mMdr = '0; mOut = '0;
        for (int i = 0; i < 16; i++) mRegs[i] = '0;
        mQKnown   = 1'b1;
        mMdrKnown = 1'b1;
    endtask

    // One rising edge of the reference model, computed from the values before the edge.
    task automatic modelEdge();
        logic [15:0] nA, nB, nAlu, nQ, opX, opY;
        bit          nQKnown;
        int          w;
        if (!rstN) begin
            modelReset();
            return;
        end
        w    = int'(memAddr[8:1]);
        opX  = aluSrcA ? pc : mA;
        opY  = aluSrcB ? immOf(mIr, numBits, immShift) : mB;
        nAlu = aluOf(aluOp, opX, opY);
        nA   = (mIr[11:8] == 4'd0) ? 16'h0 : mRegs[mIr[11:8]];
        nB   = (mIr[7:4]  == 4'd0) ? 16'h0 : mRegs[mIr[7:4]];
        if (w == 255) begin
            nQ = inputWire; nQKnown = 1'b1;
        end else begin
            nQ = mMem[w]; nQKnown = mValid[w];
        end
        mMdr = mMemQ; mMdrKnown = mQKnown;
        mMemQ = nQ;   mQKnown   = nQKnown;
        if (writeEnable && mIr[11:8] != 4'd0) mRegs[mIr[11:8]] = dataWrite;
        if (memWe) begin
            mMem[w] = memData; mValid[w] = 1'b1;
            if (w == 254) mOut = memData;
        end
        if (irWrite) mIr = instruction;
        mA = nA; mB = nB; mAlu = nAlu;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("A", a, mA);
        checkOutput("B", b, mB);
        checkOutput("ALUOut", aluOut, mAlu);
        checkOutput("Op", {12'h0, op}, {12'h0, mIr[15:12]});
        checkOutput("imm", imm, immOf(mIr, numBits, immShift));
        checkOutput("outputWire", outputWire, mOut);
        if (mQKnown)   checkOutput("memQ", memQ, mMemQ);
        if (mMdrKnown) checkOutput("MDROut", mdrOut, mMdr);
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    initial begin
        rstN = 1'b0; aluOp = '0; aluSrcA = 0; aluSrcB = 0; writeEnable = 0; irWrite = 0;
        memWe = 0; dataWrite = '0; instruction = '0; pc = '0; memData = '0; memAddr = '0;
        inputWire = '0; immShift = '0; numBits = '0;
        for (int i = 0; i < 256; i++) mValid[i] = 1'b0;
        modelReset();

        applyStimulus();
        applyStimulus();
        rstN = 1'b1;

        // Register write then read back through A and B
        instruction = 16'h0310; irWrite = 1; writeEnable = 1; dataWrite = 16'h1234;
        applyStimulus();
        irWrite = 0;
        applyStimulus();
        applyStimulus();
        checkOutput("regA_r3", a, 16'h1234);
        writeEnable = 0;
        instruction = 16'h0330; irWrite = 1;
        applyStimulus();
        irWrite = 0;
        applyStimulus();
        checkOutput("regB_r3", b, 16'h1234);
        instruction = 16'h0000; irWrite = 1; writeEnable = 1; dataWrite = 16'hFFFF;
        applyStimulus();
        irWrite = 0;
        applyStimulus();
        applyStimulus();
        checkOutput("r0_zero", a, 16'h0000);
        writeEnable = 0;

        // ALU with A=7, B=-9, then signed overflow wrap
        instruction = 16'h0100; irWrite = 1;
        applyStimulus();
        irWrite = 0; writeEnable = 1; dataWrite = 16'h0007;
        applyStimulus();
        writeEnable = 0; instruction = 16'h0200; irWrite = 1;
        applyStimulus();
        irWrite = 0; writeEnable = 1; dataWrite = 16'hFFF7;
        applyStimulus();
        writeEnable = 0; instruction = 16'h0121; irWrite = 1;
        applyStimulus();
        irWrite = 0;
        applyStimulus();
        aluOp = 3'd0;
        applyStimulus();
        checkOutput("alu_add", aluOut, 16'hFFFE);
        aluOp = 3'd7;
        applyStimulus();
        checkOutput("alu_slt", aluOut, 16'h0000);
        pc = 16'h7FFF; aluSrcA = 1; aluSrcB = 1; numBits = 2'd0; immShift = 2'd0; aluOp = 3'd0;
        applyStimulus();
        checkOutput("alu_wrap", aluOut, 16'h8000);
        aluSrcA = 0; aluSrcB = 0;

        // Immediate generator
        instruction = 16'h00F0; irWrite = 1;
        applyStimulus();
        irWrite = 0; numBits = 2'd1; immShift = 2'd2;
        #1;
        checkOutput("imm_sext8", imm, 16'hFFC0);
        numBits = 2'd3;
        #1;
        checkOutput("imm_zext8", imm, 16'h03C0);

        // Memory, MDR, read-during-write, I/O mapping, ignored address bits
        memWe = 1; memAddr = 16'h0004; memData = 16'hBEEF;
        applyStimulus();
        memWe = 0;
        applyStimulus();
        checkOutput("mem_read", memQ, 16'hBEEF);
        applyStimulus();
        checkOutput("mdr", mdrOut, 16'hBEEF);
        memWe = 1; memData = 16'h1111;
        applyStimulus();
        checkOutput("mem_rdw_old", memQ, 16'hBEEF);
        memWe = 0;
        applyStimulus();
        checkOutput("mem_rdw_new", memQ, 16'h1111);
        memWe = 1; memAddr = 16'h01FC; memData = 16'hCAFE;
        applyStimulus();
        checkOutput("io_out", outputWire, 16'hCAFE);
        memWe = 0; memAddr = 16'h01FE; inputWire = 16'h5A5A;
        applyStimulus();
        checkOutput("io_in", memQ, 16'h5A5A);
        memAddr = 16'hFE05;
        applyStimulus();
        checkOutput("addr_alias", memQ, 16'h1111);

        // Asynchronous reset mid-cycle, with a write pending while held
        #2;
        rstN = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkOutput("rst_outWire", outputWire, 16'h0000);
        memWe = 1; memAddr = 16'h0004; memData = 16'h2222;
        applyStimulus();
        rstN = 1'b1; memWe = 0;
        applyStimulus();
        checkOutput("rst_abort_write", memQ, 16'h1111);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [15:0] r;
            int          sel;
            logic [7:0]  word;
            r   = 16'($urandom);
            sel = $urandom_range(0, 17);
            word = (sel < 16) ? 8'(sel) : ((sel == 16) ? 8'hFE : 8'hFF);
            memAddr     = {r[15:9], word, r[0]};
            memWe       = 1'($urandom);
            memData     = 16'($urandom);
            inputWire   = 16'($urandom);
            aluOp       = 3'($urandom);
            aluSrcA     = 1'($urandom);
            aluSrcB     = 1'($urandom);
            writeEnable = 1'($urandom);
            dataWrite   = 16'($urandom);
            immShift    = 2'($urandom);
            numBits     = 2'($urandom);
            irWrite     = 1'($urandom);
            instruction = 16'($urandom);
            pc          = 16'($urandom);
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/datapath_mem_core.md
DATAPATH_MEM_CORE -- requirements
Module: datapath_mem_core

Interface
REQ-001 Parameter DATA_W, default 16, datapath, register and memory word width.
REQ-002 Parameter MEM_DEPTH, default 256, number of memory words.
REQ-003 Parameter IO_IN_ADDR, default 8'hFF, word address that reads inputWire.
REQ-004 Parameter IO_OUT_ADDR, default 8'hFE, word address whose writes drive outputWire.
REQ-005 CLK  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 ALUOp  in  3  ALU operation select.
REQ-008 ALUSrcA  in  1  ALU operand A select: 0 = A, 1 = PC.
REQ-009 ALUSrcB  in  1  ALU operand B select: 0 = B, 1 = immediateGenerated.
REQ-010 writeEnable  in  1  register-file write strobe.
REQ-011 dataWrite  in  16  register-file write data.
REQ-012 immShift  in  2  immediate left-shift amount (0-3).
REQ-013 numBits  in  2  immediate field select.
REQ-014 IRWrite  in  1  instruction register load enable.
REQ-015 instruction  in  16  instruction word to load into the IR.
REQ-016 PC  in  16  program counter value.
REQ-017 memData  in  16  memory write data.
REQ-018 memAddr  in  16  memory byte address; word index = memAddr[8:1].
REQ-019 memWe  in  1  memory write enable.
REQ-020 inputWire  in  16  external input port, mapped at IO_IN_ADDR.
REQ-021 A, B  out  16 each  signed register-file read registers.
REQ-022 ALUOut  out  16  signed registered ALU result.
REQ-023 Op  out  4  opcode, equal to IR[15:12].
REQ-024 immediateGenerated  out  16  combinational immediate.
REQ-025 memQ  out  16  registered memory read data.
REQ-026 MDROut  out  16  memory data register output.
REQ-027 outputWire  out  16  external output port register.

Function
REQ-028 IR SHALL load `instruction` on each edge where IRWrite=1 and otherwise hold.
REQ-029 Register file SHALL contain 16 x 16-bit registers with fields rd=IR[11:8], rs=IR[7:4]; r0 SHALL read 0, and writes to r0 SHALL be ignored.
REQ-030 Each edge SHALL perform A<=reg[rd] and B<=reg[rs] (one-cycle latency after the IR loads).
REQ-031 When writeEnable=1, each edge SHALL perform reg[rd]<=dataWrite; A and B SHALL sample the pre-write value on that same edge.
REQ-032 immediateGenerated SHALL be formed by selecting a field and then shifting left by immShift, truncated to 16 bits:
- numBits=0: sign-extended IR[3:0]
- numBits=1: sign-extended IR[7:0]
- numBits=2: sign-extended IR[11:0]
- numBits=3: zero-extended IR[7:0]
REQ-033 ALU SHALL be signed 16-bit with wrap-around and no flags; ALUOp encoding:
- 0 = add, 1 = sub, 2 = and, 3 = or, 4 = xor
- 5 = shift left by b[3:0]
- 6 = arithmetic shift right by b[3:0]
- 7 = set-less-than (signed; result 1 or 0)
REQ-034 ALUOut SHALL register the ALU result on every edge.
REQ-035 Memory SHALL be MEM_DEPTH x 16 with a synchronous write (when memWe=1) and a registered read: memQ<=mem[word] each edge.
REQ-036 Read-during-write to the same word SHALL return the old data.
REQ-037 A read at IO_IN_ADDR SHALL return inputWire as sampled at that edge.
REQ-038 A write to IO_OUT_ADDR SHALL update both outputWire and the array.
REQ-039 MDR SHALL load memQ on every edge while reset is deasserted.
REQ-040 Address bits [15:9] and [0] SHALL be ignored.

Reset
REQ-041 While reset=0, the following SHALL clear to 0 immediately, independent of CLK: IR, Op, all register-file registers, A, B, ALUOut, memQ, MDROut, outputWire.
REQ-042 The memory array SHALL NOT be cleared by reset.
REQ-043 Writes SHALL be blocked while reset=0.
REQ-044 Operation SHALL resume on the first rising edge after reset deasserts.
REQ-045 Reset asserted mid-operation SHALL abort any pending write.

Verification
REQ-046 Reset: assert reset=0 between edges -> all outputs listed in REQ-041 read 0 before the next edge.
REQ-047 Register write/read, in order:
- load IR=16'h0310, writeEnable=1, dataWrite=16'h1234
- one edge later, A=16'h1234
- after a second write cycle, with IR rd=3 and rs=3, B=16'h1234
- writes with rd=0 leave r0=0
REQ-048 ALU: A=7, B=-9, ALUOp=0 -> ALUOut=-2; ALUOp=7 -> 0; with 16'h7FFF+1, ALUOp=0 -> 16'h8000.
REQ-049 Immediate: IR[7:0]=8'hF0, numBits=1, immShift=2 -> immediateGenerated=16'hFFC0; with numBits=3 -> 16'h03C0.
REQ-050 Memory:
- write 16'hBEEF at memAddr=16'h0004 -> memQ=16'hBEEF one edge after the read, and MDROut=16'hBEEF one edge after memQ
- write at memAddr=16'h01FC -> outputWire updated
- read at memAddr=16'h01FE -> memQ equals inputWire
